imem_loader: RTL and testbench

//  Boot-time writer for the instruction memory. Takes a byte stream over a

---
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a 16-bit word count and then
// little-endian 32-bit words over a byte handshake, and issues one write per word.
module imem_loader #(
  parameter int addr_ins_width = 32,
  parameter int memory_width   = 32,
  parameter int memory_height  = 512,
  parameter int load_base      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      byte_valid,
  input  logic [7:0]                byte_data,
  output logic                      byte_ready,
  output logic                      wr_en,
  output logic [addr_ins_width-1:0] wr_addr,
  output logic [memory_width-1:0]   wr_data,
  output logic                      cpu_hold,
  output logic                      done,
  output logic                      err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_HDR_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam logic [31:0]               max_cnt_c   = 32'(memory_height - load_base);
  localparam logic [addr_ins_width-1:0] base_addr_c = addr_ins_width'(load_base);
  localparam logic [addr_ins_width-1:0] addr_one_c  = {{(addr_ins_width-1){1'b0}}, 1'b1};

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  cnt_lo_r;
  logic [15:0] remain_r;
  logic [1:0]  byte_idx_r;
  logic        xfer_s;
  logic [15:0] cnt_full_s;

  assign xfer_s     = byte_valid & byte_ready;
  assign cnt_full_s = {byte_data, cnt_lo_r};

  // Byte acceptance decoded straight from the current state.
  always_comb begin
    byte_ready = 1'b0;
    case (state_r)
      ST_HDR_LO, ST_HDR_HI, ST_DATA: byte_ready = 1'b1;
      default:                       byte_ready = 1'b0;
    endcase
  end

  // Next-state logic; start is only honoured in the idle/terminal states.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_HDR_LO;
        else       state_s = state_r;
      end
      ST_HDR_LO: begin
        if (xfer_s) state_s = ST_HDR_HI;
        else        state_s = state_r;
      end
      ST_HDR_HI: begin
        if (!xfer_s)                                state_s = state_r;
        else if (cnt_full_s == 16'd0)               state_s = ST_DONE;
        else if ({16'd0, cnt_full_s} > max_cnt_c)   state_s = ST_ERR;
        else                                        state_s = ST_DATA;
      end
      ST_DATA: begin
        if (xfer_s && (byte_idx_r == 2'd3)) state_s = ST_WRITE;
        else                                state_s = state_r;
      end
      ST_WRITE: begin
        if (remain_r == 16'd1) state_s = ST_DONE;
        else                   state_s = ST_DATA;
      end
      ST_DONE, ST_ERR: begin
        if (start) state_s = ST_HDR_LO;
        else       state_s = state_r;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      wr_en    <= (state_s == ST_WRITE);
      done     <= (state_s == ST_DONE);
      err      <= (state_s == ST_ERR);
      cpu_hold <= (state_s != ST_DONE);
    end
  end

  // Header capture, word assembly and write address/remaining-count tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lo_r   <= 8'd0;
      remain_r   <= 16'd0;
      byte_idx_r <= 2'd0;
      wr_addr    <= base_addr_c;
      wr_data    <= {memory_width{1'b0}};
    end else begin
      case (state_r)
        ST_HDR_LO: begin
          if (xfer_s) cnt_lo_r <= byte_data;
        end
        ST_HDR_HI: begin
          if (xfer_s) begin
            remain_r   <= cnt_full_s;
            wr_addr    <= base_addr_c;
            byte_idx_r <= 2'd0;
          end
        end
        ST_DATA: begin
          if (xfer_s) begin
            wr_data[{byte_idx_r, 3'b000} +: 8] <= byte_data;
            byte_idx_r                         <= byte_idx_r + 2'd1;
          end
        end
        ST_WRITE: begin
          wr_addr  <= wr_addr + addr_one_c;
          remain_r <= remain_r - 16'd1;
        end
        default: begin
          remain_r <= remain_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as bytes are sent
// and compared against every wr_en strobe observed by the monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_wr = 0;
  int          wr_snap;
  logic [63:0] sb_q[$];
  logic [31:0] img[16];

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      logic [63:0] exp_w;
      n_wr = n_wr + 1;
      chk("ready_in_write", 64'(byte_ready), 64'd0);
      chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        exp_w = sb_q.pop_front();
        chk("wr_word", {wr_addr, wr_data}, exp_w);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    bit ok = 1'b0;
    int tries = 0;
    byte_valid = 1'b0;
    repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!ok && tries < 50) begin
      ok = byte_ready;
      @(negedge clk);
      tries++;
    end
    byte_valid = 1'b0;
    chk("byte_accept", 64'(ok), 64'd1);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_hold", 64'(cpu_hold), 64'd1);
    chk("start_done", 64'(done), 64'd0);
    chk("start_err", 64'(err), 64'd0);
  endtask

  task automatic send_hdr(input logic [15:0] cnt, input int max_gap);
    send_byte(cnt[7:0], max_gap);
    send_byte(cnt[15:8], max_gap);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] addr,
                           input int max_gap, input bit glitch);
    for (int k = 0; k < 4; k++) begin
      if (glitch && k == 1) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if (k == 3) sb_q.push_back({addr, w});
      send_byte(w[8*k +: 8], max_gap);
    end
    chk("wr_en_latency", 64'(wr_en), 64'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
    chk("done_level", 64'(done), 64'd1);
    chk("done_hold", 64'(cpu_hold), 64'd0);
    chk("done_err", 64'(err), 64'd0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic load(input int cnt, input int max_gap, input bit glitch);
    do_start();
    send_hdr(16'(cnt), max_gap);
    for (int i = 0; i < cnt; i++) send_word(img[i], 32'(i), max_gap, glitch && (i == 0));
    wait_done();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, 64'(byte_ready), 64'd0);
    chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    chk({tag, "_addr"}, 64'(wr_addr), 64'd0);
    chk({tag, "_data"}, 64'(wr_data), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_hold"}, 64'(cpu_hold), 64'd1);
  endtask

  initial begin
    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(byte_ready), 64'd0);

    // Two-word image from the reference byte stream
    img[0] = 32'h0020A103;
    img[1] = 32'h00118293;
    load(2, 0, 1'b0);

    // Empty image: done straight after the header, no writes
    wr_snap = n_wr;
    do_start();
    send_hdr(16'd0, 0);
    chk("cnt0_done", 64'(done), 64'd1);
    chk("cnt0_hold", 64'(cpu_hold), 64'd0);
    repeat (3) @(negedge clk);
    chk("cnt0_no_wr", 64'(n_wr), 64'(wr_snap));

    // Oversized count errors out; start clears it; 512 is still legal
    do_start();
    send_hdr(16'd513, 0);
    chk("err_level", 64'(err), 64'd1);
    chk("err_hold", 64'(cpu_hold), 64'd1);
    chk("err_done", 64'(done), 64'd0);
    chk("err_ready", 64'(byte_ready), 64'd0);
    repeat (5) @(negedge clk);
    chk("err_sticky", 64'(err), 64'd1);
    chk("err_no_wr", 64'(n_wr), 64'(wr_snap));
    do_start();
    chk("err_restart_ready", 64'(byte_ready), 64'd1);
    send_hdr(16'd512, 0);
    chk("max_cnt_err", 64'(err), 64'd0);
    chk("max_cnt_data", 64'(byte_ready), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst2");
    rst = 1'b0;
    @(negedge clk);

    // Seven words gapless, then the same image with random valid gaps
    for (int i = 0; i < 7; i++) img[i] = $urandom;
    load(7, 0, 1'b0);
    load(7, 3, 1'b0);

    // Reset part-way through word 3 discards it; fresh load starts at base
    do_start();
    send_hdr(16'd5, 0);
    for (int i = 0; i < 3; i++) send_word(img[i], 32'(i), 0, 1'b0);
    send_byte(img[3][7:0], 0);
    send_byte(img[3][15:8], 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst3");
    rst = 1'b0;
    @(negedge clk);
    chk("rst3_no_wr", 64'(wr_en), 64'd0);
    img[0] = 32'hDEADBEEF;
    load(1, 0, 1'b0);

    // Start during DATA is ignored; start in DONE reloads from base
    img[0] = 32'h12345678;
    img[1] = 32'h9ABCDEF0;
    load(2, 0, 1'b1);
    img[0] = 32'hCAFEF00D;
    load(1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
